// File: rtl/l2_block_responder_if.sv
// L1 <-> L2 block transfer bus: request/address/write data from L1,
// refill data, valid, stall and flush command back from L2.
interface l2_block_responder_if #(
    parameter int n          = 32,
    parameter int addr_width = 15
);
    logic                  L2_read_request;
    logic                  L2_write_request;
    logic [addr_width-1:0] L2_word_address;
    logic [n-1:0]          L2_write_word;
    logic [n-1:0]          L2_read_word;
    logic                  L2_word_valid;
    logic                  L2_busy;
    logic                  flush;

    modport master (
        output L2_read_request, L2_write_request, L2_word_address, L2_write_word,
        input  L2_read_word, L2_word_valid, L2_busy, flush
    );

    modport slave (
        input  L2_read_request, L2_write_request, L2_word_address, L2_write_word,
        output L2_read_word, L2_word_valid, L2_busy, flush
    );
endinterface

// File: rtl/l2_block_responder.sv
// L2-side responder for the L1 refill/write-back protocol: serves 16-word
// block reads and writes from a word-addressed backing store and issues L1 flushes.
module l2_block_responder #(
    parameter int n          = 32,
    parameter int block_size = 16,
    parameter int addr_width = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    l2_block_responder_if.slave  l2,
    input  logic                 ext_stall,
    input  logic                 flush_req,
    output logic [15:0]          block_reads,
    output logic [15:0]          block_writes
);
    localparam int beat_width = $clog2(block_size);
    localparam logic [beat_width-1:0] last_beat   = beat_width'(block_size - 1);
    localparam logic [addr_width-1:0] offset_mask = addr_width'(block_size - 1);

    typedef enum logic [1:0] {IDLE, READ_BURST, WRITE_BURST, FLUSH} state_t;

    state_t                state;
    logic [addr_width-1:0] base_addr;
    logic [beat_width-1:0] beat;
    logic [beat_width-1:0] next_beat;
    logic                  flush_pending;
    logic [n-1:0]          read_word_q;
    logic                  word_valid_q;
    logic                  busy_q;
    logic                  flush_q;
    logic [addr_width-1:0] accept_base;
    logic [addr_width-1:0] cur_addr;
    logic [addr_width-1:0] next_addr;

    logic [n-1:0] mem [2**addr_width];

    // Block alignment keeps base|beat inside the block, so addresses wrap within it.
    assign next_beat   = beat + 1'b1;
    assign accept_base = l2.L2_word_address & ~offset_mask;
    assign cur_addr    = base_addr | addr_width'(beat);
    assign next_addr   = base_addr | addr_width'(next_beat);

    assign l2.L2_read_word  = read_word_q;
    assign l2.L2_word_valid = word_valid_q;
    assign l2.L2_busy       = busy_q;
    assign l2.flush         = flush_q;

    // Backing store is deliberately not reset; state returns to IDLE on reset so no stray store.
    always_ff @(posedge clk) begin
        if (state == WRITE_BURST && !ext_stall)
            mem[cur_addr] <= l2.L2_write_word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            base_addr     <= '0;
            beat          <= '0;
            flush_pending <= 1'b0;
            read_word_q   <= '0;
            word_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            flush_q       <= 1'b0;
            block_reads   <= '0;
            block_writes  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    word_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    flush_q      <= 1'b0;
                    if (flush_pending || flush_req) begin
                        state   <= FLUSH;
                        flush_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (l2.L2_write_request) begin
                        state     <= WRITE_BURST;
                        base_addr <= accept_base;
                        beat      <= '0;
                    end else if (l2.L2_read_request) begin
                        state        <= READ_BURST;
                        base_addr    <= accept_base;
                        beat         <= '0;
                        read_word_q  <= mem[accept_base];
                        word_valid_q <= 1'b1;
                    end
                end

                READ_BURST: begin
                    if (flush_req)
                        flush_pending <= 1'b1;
                    if (ext_stall) begin
                        word_valid_q <= 1'b0;
                        busy_q       <= 1'b1;
                    end else if (beat == last_beat) begin
                        word_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                        if (block_reads != 16'hFFFF)
                            block_reads <= block_reads + 16'd1;
                    end else begin
                        beat         <= next_beat;
                        read_word_q  <= mem[next_addr];
                        word_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                    end
                end

                WRITE_BURST: begin
                    if (flush_req)
                        flush_pending <= 1'b1;
                    if (ext_stall) begin
                        busy_q <= 1'b1;
                    end else if (beat == last_beat) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                        if (block_writes != 16'hFFFF)
                            block_writes <= block_writes + 16'd1;
                    end else begin
                        beat   <= next_beat;
                        busy_q <= 1'b0;
                    end
                end

                FLUSH: begin
                    flush_q       <= 1'b0;
                    busy_q        <= 1'b0;
                    flush_pending <= 1'b0;
                    state         <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_block_responder.sv
// Directed bench for l2_block_responder: table of block transfers plus
// hand-written stall, arbitration/flush and mid-burst reset sequences.
module tb_l2_block_responder;
    localparam int n          = 32;
    localparam int block_size = 16;
    localparam int addr_width = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ext_stall;
    logic        flush_req;
    logic [15:0] block_reads;
    logic [15:0] block_writes;

    int check_count = 0;
    int fail_count  = 0;

    typedef struct {
        logic                  is_write;
        logic [addr_width-1:0] addr;
        logic [n-1:0]          data0;
        logic [n-1:0]          step;
        logic [15:0]           exp_reads;
        logic [15:0]           exp_writes;
    } block_vec_t;

    block_vec_t vecs[7];

    l2_block_responder_if #(.n(n), .addr_width(addr_width)) l2_bus ();

    l2_block_responder #(
        .n(n), .block_size(block_size), .addr_width(addr_width)
    ) dut (
        .clk(clk),
        .reset(reset),
        .l2(l2_bus.slave),
        .ext_stall(ext_stall),
        .flush_req(flush_req),
        .block_reads(block_reads),
        .block_writes(block_writes)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [addr_width-1:0] addr,
                                 input logic [n-1:0] wdata, input logic stall, input logic freq);
        l2_bus.L2_read_request  = rd;
        l2_bus.L2_write_request = wr;
        l2_bus.L2_word_address  = addr;
        l2_bus.L2_write_word    = wdata;
        ext_stall               = stall;
        flush_req               = freq;
    endtask

    task automatic runWrite(input block_vec_t v);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, v.addr, '0, 1'b0, 1'b0);
        for (int k = 0; k < block_size; k++) begin
            @(negedge clk);
            checkOutput("wr_busy", 32'(l2_bus.L2_busy), 32'd0);
            applyStimulus(1'b0, 1'b0, v.addr, v.data0 + v.step * 32'(k), 1'b0, 1'b0);
        end
        @(negedge clk);
        checkOutput("wr_block_writes", 32'(block_writes), 32'(v.exp_writes));
        checkOutput("wr_block_reads", 32'(block_reads), 32'(v.exp_reads));
        checkOutput("wr_end_valid", 32'(l2_bus.L2_word_valid), 32'd0);
    endtask

    task automatic runRead(input block_vec_t v);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, v.addr, '0, 1'b0, 1'b0);
        for (int k = 0; k < block_size; k++) begin
            @(negedge clk);
            checkOutput("rd_valid", 32'(l2_bus.L2_word_valid), 32'd1);
            checkOutput("rd_data", l2_bus.L2_read_word, v.data0 + v.step * 32'(k));
            checkOutput("rd_busy", 32'(l2_bus.L2_busy), 32'd0);
            applyStimulus(1'b0, 1'b0, v.addr, '0, 1'b0, 1'b0);
        end
        @(negedge clk);
        checkOutput("rd_end_valid", 32'(l2_bus.L2_word_valid), 32'd0);
        checkOutput("rd_block_reads", 32'(block_reads), 32'(v.exp_reads));
        checkOutput("rd_block_writes", 32'(block_writes), 32'(v.exp_writes));
    endtask

    initial begin
        vecs[0] = '{1'b1, 15'd1000,  32'd0,          32'd5, 16'd0, 16'd1};
        vecs[1] = '{1'b0, 15'd1003,  32'd0,          32'd5, 16'd1, 16'd1};
        vecs[2] = '{1'b1, 15'd32767, 32'hA000_0000,  32'd1, 16'd1, 16'd2};
        vecs[3] = '{1'b0, 15'd32752, 32'hA000_0000,  32'd1, 16'd2, 16'd2};
        vecs[4] = '{1'b1, 15'd0,     32'hFFFF_FFF0,  32'd1, 16'd2, 16'd3};
        vecs[5] = '{1'b0, 15'd15,    32'hFFFF_FFF0,  32'd1, 16'd3, 16'd3};
        vecs[6] = '{1'b0, 15'd1007,  32'd0,          32'd5, 16'd4, 16'd3};

        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_read_word", l2_bus.L2_read_word, 32'd0);
        checkOutput("rst_valid", 32'(l2_bus.L2_word_valid), 32'd0);
        checkOutput("rst_busy", 32'(l2_bus.L2_busy), 32'd0);
        checkOutput("rst_flush", 32'(l2_bus.flush), 32'd0);
        checkOutput("rst_block_reads", 32'(block_reads), 32'd0);
        checkOutput("rst_block_writes", 32'(block_writes), 32'd0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].is_write)
                runWrite(vecs[i]);
            else
                runRead(vecs[i]);
        end

        // Stall in IDLE must not raise busy; then stall a refill for 2 cycles after beat 5.
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("idle_stall_busy", 32'(l2_bus.L2_busy), 32'd0);
        applyStimulus(1'b1, 1'b0, 15'd992, '0, 1'b0, 1'b0);
        for (int cyc = 1; cyc <= 18; cyc++) begin
            @(negedge clk);
            if (cyc == 7 || cyc == 8) begin
                checkOutput("stall_valid", 32'(l2_bus.L2_word_valid), 32'd0);
                checkOutput("stall_busy", 32'(l2_bus.L2_busy), 32'd1);
                checkOutput("stall_hold_data", l2_bus.L2_read_word, 32'd25);
            end else begin
                checkOutput("stall_rd_valid", 32'(l2_bus.L2_word_valid), 32'd1);
                checkOutput("stall_rd_busy", 32'(l2_bus.L2_busy), 32'd0);
                checkOutput("stall_rd_data", l2_bus.L2_read_word,
                            32'd5 * 32'((cyc <= 6) ? cyc - 1 : cyc - 3));
            end
            applyStimulus(1'b0, 1'b0, 15'd992, '0, (cyc == 6 || cyc == 7), 1'b0);
        end
        @(negedge clk);
        checkOutput("stall_end_valid", 32'(l2_bus.L2_word_valid), 32'd0);
        checkOutput("stall_block_reads", 32'(block_reads), 32'd5);

        // Fresh counters, then simultaneous requests with a flush raised mid write burst.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 15'd2048, '0, 1'b0, 1'b0);
        for (int k = 0; k < block_size; k++) begin
            @(negedge clk);
            checkOutput("arb_wr_valid", 32'(l2_bus.L2_word_valid), 32'd0);
            checkOutput("arb_wr_flush", 32'(l2_bus.flush), 32'd0);
            applyStimulus(1'b1, 1'b0, 15'd2048, 32'd100 + 32'(k), 1'b0, (k == 4));
        end
        @(negedge clk);
        checkOutput("arb_idle_flush", 32'(l2_bus.flush), 32'd0);
        checkOutput("arb_idle_busy", 32'(l2_bus.L2_busy), 32'd0);
        checkOutput("arb_block_writes", 32'(block_writes), 32'd1);
        @(negedge clk);
        checkOutput("flush_pulse", 32'(l2_bus.flush), 32'd1);
        checkOutput("flush_busy", 32'(l2_bus.L2_busy), 32'd1);
        checkOutput("flush_valid", 32'(l2_bus.L2_word_valid), 32'd0);
        @(negedge clk);
        checkOutput("post_flush", 32'(l2_bus.flush), 32'd0);
        checkOutput("post_flush_busy", 32'(l2_bus.L2_busy), 32'd0);
        checkOutput("post_flush_valid", 32'(l2_bus.L2_word_valid), 32'd0);
        for (int k = 0; k < block_size; k++) begin
            @(negedge clk);
            checkOutput("arb_rd_valid", 32'(l2_bus.L2_word_valid), 32'd1);
            checkOutput("arb_rd_data", l2_bus.L2_read_word, 32'd100 + 32'(k));
            applyStimulus(1'b0, 1'b0, 15'd2048, '0, 1'b0, 1'b0);
        end
        @(negedge clk);
        checkOutput("arb_end_valid", 32'(l2_bus.L2_word_valid), 32'd0);
        checkOutput("arb_block_reads", 32'(block_reads), 32'd1);
        checkOutput("arb_block_writes_final", 32'(block_writes), 32'd1);

        // Reset lands while write beat 7 is on the bus; beats 0..6 must stick.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 15'd2048, '0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 15'd2048, 32'h5000 + 32'(k), 1'b0, 1'b0);
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 15'd2048, 32'h5007, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(l2_bus.L2_busy), 32'd0);
        checkOutput("midrst_valid", 32'(l2_bus.L2_word_valid), 32'd0);
        checkOutput("midrst_flush", 32'(l2_bus.flush), 32'd0);
        checkOutput("midrst_read_word", l2_bus.L2_read_word, 32'd0);
        checkOutput("midrst_block_writes", 32'(block_writes), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 15'd2050, '0, 1'b0, 1'b0);
        for (int k = 0; k < block_size; k++) begin
            @(negedge clk);
            checkOutput("partial_valid", 32'(l2_bus.L2_word_valid), 32'd1);
            checkOutput("partial_data", l2_bus.L2_read_word,
                        (k < 7) ? 32'h5000 + 32'(k) : 32'd100 + 32'(k));
            applyStimulus(1'b0, 1'b0, 15'd2050, '0, 1'b0, 1'b0);
        end
        @(negedge clk);
        checkOutput("partial_block_reads", 32'(block_reads), 32'd1);
        checkOutput("partial_block_writes", 32'(block_writes), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end
endmodule

// File: doc/l2_block_responder.md
Name: l2_block_responder

Overview:
- L2-side responder for the L1 data cache's L2 interface; the other end of the L1 refill/write-back protocol.
- Serves 16-word block reads (refill) and 16-word block writes (write-back) from an internal word-addressed backing store.
- Streams one 32-bit word per cycle and stalls L1 via L2_busy when external contention is signalled.
- Issues the flush command to L1 on request from the coherence controller.

Parameters:
- n, 32, data word width in bits
- block_size, 16, words per cache block; must be a power of 2
- addr_width, 15, word address width; backing store depth is 2**addr_width words

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- L2_read_request  input  1  L1 requests a block refill
- L2_write_request  input  1  L1 requests a block write-back
- L2_word_address  input  addr_width  word address from L1; block base = address with low log2(block_size) bits cleared
- L2_write_word  input  n  write-back data word from L1, one per beat
- L2_read_word  output  n  refill data word to L1, one per beat
- L2_word_valid  output  1  L2_read_word holds a valid refill beat this cycle
- L2_busy  output  1  L1 clock enable: 1 = L1 must hold state
- flush  output  1  one-cycle command to L1 to invalidate all contents
- ext_stall  input  1  external contention; pauses any active burst
- flush_req  input  1  coherence controller requests an L1 flush (level, sampled)
- block_reads  output  16  saturating count of completed read bursts
- block_writes  output  16  saturating count of completed write bursts

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; beat counter 0.
  - All outputs 0: L2_read_word, L2_word_valid, L2_busy, flush, block_reads, block_writes.
  - flush_pending is cleared. Backing store is not reset.
- State machine: IDLE, READ_BURST, WRITE_BURST, FLUSH.
- IDLE arbitration at each rising edge, highest priority first:
  - flush_pending or flush_req -> FLUSH.
  - L2_write_request -> WRITE_BURST. Write-back wins over refill when both are asserted.
  - L2_read_request -> READ_BURST.
- On accept: latch block base from L2_word_address and clear the beat counter. Requests are sampled only at accept; request deassertion mid-burst is ignored.
- READ_BURST:
  - The accepting edge registers L2_read_word = mem[base+0] and sets L2_word_valid=1.
  - Each later non-stalled edge advances to mem[base+k]. Beat k is therefore valid in the (k+1)-th cycle after accept.
  - After the block_size-th beat: L2_word_valid=0, block_reads increments, state returns to IDLE.
  - Minimum latency: 16 data cycles, then 1 IDLE cycle before the next accept.
- WRITE_BURST:
  - Each non-stalled cycle in this state stores L2_write_word into mem[base+k] at the rising edge, then k increments.
  - The first sample is taken at the edge one cycle after accept.
  - After beat block_size-1 is stored: block_writes increments, state returns to IDLE.
- Stall during a burst:
  - While ext_stall=1: L2_busy=1 and the beat counter holds.
  - In READ_BURST, L2_read_word holds its current value and L2_word_valid=0.
  - In WRITE_BURST, no store occurs.
  - ext_stall in IDLE has no effect.
- L2_busy = 1 during a stalled burst cycle and during the FLUSH cycle; 0 otherwise, including all IDLE cycles.
- FLUSH: lasts exactly one cycle with flush=1 and L2_busy=1, clears flush_pending, then returns to IDLE.
- flush_req asserted during a burst sets flush_pending. The flush is issued in the first IDLE cycle after the burst, ahead of any waiting request.
- Address arithmetic: base+k is modulo 2**addr_width; the last block wraps to word 0 of its own block. Block alignment means no overflow past the top of memory.
- Counters saturate at 16'hFFFF.
- Reset asserted mid-burst aborts immediately. Words already written by the partial burst remain in memory; no counter increments.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> all outputs 0, state IDLE.
- Write-back at address 1000: L2_write_request=1 with L2_word_address=1000, drive L2_write_word=5*k for beats k=0..15 -> mem[992..1007]=0,5,..,75; block_writes=1.
- Refill of the same block: L2_read_request=1 at address 1003 -> L2_word_valid high for 16 cycles; L2_read_word sequence 0,5,..,75 starting the cycle after accept; block_reads=1.
- Stall mid-refill: assert ext_stall for 2 cycles after beat 5 -> L2_busy=1 and valid=0 for 2 cycles, beat 5 value held; beats resume at 6; total burst duration 18 cycles.
- Simultaneous read and write request, plus flush_req raised mid-burst:
  - Write burst runs first, then a 1-cycle flush=1 pulse with L2_busy=1, then the read burst.
  - Final state: block_writes=1, block_reads=1.
- Reset pulse at write beat 7 -> mem[base+0..6] updated, mem[base+7..15] unchanged, block_writes unchanged, outputs 0.
